// File: rtl/alu_seq_pkg.sv
// Shared types and defaults for the ALU request sequencer.
// Opcode encodings mirror the 2-bit board ALU.
package alu_seq_pkg;

    localparam int DATA_W_DEF = 2;
    localparam int OP_W_DEF   = 3;

    typedef enum logic [2:0] {
        GET_A    = 3'd0,
        GET_B    = 3'd1,
        GET_OP   = 3'd2,
        ISSUE    = 3'd3,
        WAIT_RSP = 3'd4,
        DONE     = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_ANDN = 3'b100,
        OP_ORN  = 3'b101,
        OP_SUB  = 3'b110,
        OP_SUBF = 3'b111
    } alu_op_e;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector for the operator confirm strobe.
// o_rise is high for the single cycle where i_sig first goes high.
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_rise
);

    logic r_stb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_stb_q <= 1'b0;
        else        r_stb_q <= i_sig;
    end

    assign o_rise = i_sig & ~r_stb_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Collects A, B and opcode from the switches, issues one ALU request and holds the result.
// Define ALU_SEQ_CHAIN_EN to let a DONE strobe reuse the previous result as operand A.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int OP_W        = OP_W_DEF,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk_2,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OP_W-1:0]   in_op,
    input  logic              in_stb,
    output logic              req_valid,
    output logic [DATA_W-1:0] req_a,
    output logic [DATA_W-1:0] req_b,
    output logic [OP_W-1:0]   req_op,
    input  logic              req_ready,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_result,
    output logic [DATA_W-1:0] res_out,
    output logic              res_valid,
    output logic              timeout_err,
    output logic [2:0]        state_dbg
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_tmo_cnt;
    logic             w_evt;

    edge_det u_edge_det (
        .clk    (clk_2),
        .rst_n  (rst_n),
        .i_sig  (in_stb),
        .o_rise (w_evt)
    );

    assign state_dbg = r_state;

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= GET_A;
            r_tmo_cnt   <= '0;
            req_valid   <= 1'b0;
            req_a       <= '0;
            req_b       <= '0;
            req_op      <= '0;
            res_out     <= '0;
            res_valid   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            unique case (r_state)
                GET_A: begin
                    if (w_evt) begin
                        req_a       <= in_data;
                        res_valid   <= 1'b0;
                        timeout_err <= 1'b0;
                        r_state     <= GET_B;
                    end
                end
                GET_B: begin
                    if (w_evt) begin
                        req_b   <= in_data;
                        r_state <= GET_OP;
                    end
                end
                GET_OP: begin
                    if (w_evt) begin
                        req_op  <= in_op;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!req_valid) begin
                        req_valid <= 1'b1;
                    end else if (req_ready) begin
                        req_valid <= 1'b0;
                        r_tmo_cnt <= '0;
                        r_state   <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    // A response on the final cycle still beats the timeout
                    if (rsp_valid) begin
                        res_out   <= rsp_result;
                        res_valid <= 1'b1;
                        r_state   <= DONE;
                    end else if (r_tmo_cnt == CNT_LAST) begin
                        res_out     <= '0;
                        timeout_err <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (w_evt) begin
`ifdef ALU_SEQ_CHAIN_EN
                        if (res_valid && !timeout_err && in_data[0])
                            req_a <= res_out;
                        else
                            req_a <= in_data;
`else
                        req_a <= in_data;
`endif
                        res_valid   <= 1'b0;
                        timeout_err <= 1'b0;
                        r_state     <= GET_B;
                    end
                end
                default: begin
                    r_state <= GET_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer.
// Chaining expectations follow ALU_SEQ_CHAIN_EN.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    logic       clk_2 = 1'b0;
    logic       rst_n;
    logic [1:0] in_data;
    logic [2:0] in_op;
    logic       in_stb;
    logic       req_valid;
    logic [1:0] req_a;
    logic [1:0] req_b;
    logic [2:0] req_op;
    logic       req_ready;
    logic       rsp_valid;
    logic [1:0] rsp_result;
    logic [1:0] res_out;
    logic       res_valid;
    logic       timeout_err;
    logic [2:0] state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk_2 = ~clk_2;

    alu_op_sequencer dut (
        .clk_2       (clk_2),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_op       (in_op),
        .in_stb      (in_stb),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_result  (rsp_result),
        .res_out     (res_out),
        .res_valid   (res_valid),
        .timeout_err (timeout_err),
        .state_dbg   (state_dbg)
    );

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic strobe(input logic [1:0] d, input logic [2:0] op);
        in_data = d;
        in_op   = op;
        in_stb  = 1'b1;
        tick();
        in_stb  = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        @(negedge clk_2);
        rst_n = 1'b1;
    endtask

    logic [1:0] exp_chain_a;

    initial begin
        rst_n      = 1'b0;
        in_data    = '0;
        in_op      = '0;
        in_stb     = 1'b0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_result = '0;
        do_reset();

        check("rst_state", 8'(state_dbg), 8'd0);
        check("rst_req_valid", 8'(req_valid), 8'd0);
        check("rst_res", 8'({res_valid, timeout_err, res_out}), 8'd0);
        check("rst_req_abop", 8'({req_a, req_b, req_op}), 8'd0);

        // ADD 2+3 -> 1 (2-bit wrap), response two cycles after transfer
        req_ready = 1'b1;
        strobe(2'd2, 3'd0);
        strobe(2'd3, 3'd0);
        strobe(2'd0, OP_ADD);
        check("add_issue_state", 8'(state_dbg), 8'd3);
        check("add_req_valid", 8'(req_valid), 8'd1);
        check("add_req_abop", 8'({req_a, req_b, req_op}), 8'b10_11_010);
        tick();
        check("add_wait_state", 8'(state_dbg), 8'd4);
        check("add_wait_valid", 8'(req_valid), 8'd0);
        tick();
        rsp_valid  = 1'b1;
        rsp_result = 2'd1;
        tick();
        rsp_valid  = 1'b0;
        check("add_state", 8'(state_dbg), 8'd5);
        check("add_res", 8'({res_valid, timeout_err, res_out}), 8'b1_0_01);

        // Backpressure: SUB 2-1 held for 5 cycles
        req_ready = 1'b0;
        strobe(2'd2, 3'd0);
        check("bp_res_cleared", 8'(res_valid), 8'd0);
        strobe(2'd1, 3'd0);
        strobe(2'd0, OP_SUB);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", 8'(req_valid), 8'd1);
            check("bp_hold_abop", 8'({req_a, req_b, req_op}), 8'b10_01_110);
            check("bp_hold_state", 8'(state_dbg), 8'd3);
        end
        req_ready = 1'b1;
        tick();
        check("bp_xfer_state", 8'(state_dbg), 8'd4);
        check("bp_xfer_valid", 8'(req_valid), 8'd0);
        tick();
        check("bp_single_xfer", 8'({req_valid, state_dbg}), 8'b0_100);
        rsp_valid  = 1'b1;
        rsp_result = 2'd1;
        tick();
        rsp_valid  = 1'b0;
        check("bp_res", 8'({state_dbg, res_valid, res_out}), 8'b101_1_01);

        // Timeout: no response for 15 cycles
        strobe(2'd0, 3'd0);
        strobe(2'd0, 3'd0);
        strobe(2'd0, OP_AND);
        tick();
        check("tmo_wait_state", 8'(state_dbg), 8'd4);
        for (int i = 0; i < 14; i++) tick();
        check("tmo_not_yet", 8'({state_dbg, timeout_err}), 8'b100_0);
        tick();
        check("tmo_state", 8'(state_dbg), 8'd5);
        check("tmo_res", 8'({res_valid, timeout_err, res_out}), 8'b0_1_00);
        rsp_valid  = 1'b1;
        rsp_result = 2'd3;
        tick();
        rsp_valid  = 1'b0;
        check("tmo_late_rsp", 8'({state_dbg, res_valid, timeout_err, res_out}),
              8'b101_0_1_00);

        // Reset mid-ISSUE, unrecognised opcode 011 still issued
        req_ready = 1'b0;
        strobe(2'd1, 3'd0);
        check("tmo_err_cleared", 8'(timeout_err), 8'd0);
        strobe(2'd2, 3'd0);
        strobe(2'd0, 3'b011);
        check("odd_op_issue", 8'({req_valid, req_op}), 8'b1_011);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 8'(req_valid), 8'd0);
        check("async_rst_state", 8'(state_dbg), 8'd0);
        check("async_rst_res", 8'(res_valid), 8'd0);
        @(negedge clk_2);
        rst_n = 1'b1;

        // Held strobe: one capture only
        in_data = 2'd3;
        in_stb  = 1'b1;
        tick();
        in_data = 2'd1;
        for (int i = 0; i < 9; i++) tick();
        in_stb = 1'b0;
        check("held_state", 8'(state_dbg), 8'd1);
        check("held_a", 8'({req_a, req_b}), 8'b11_00);
        tick();

        // Result 3, then DONE strobe with in_data=1
        req_ready = 1'b1;
        do_reset();
        strobe(2'd1, 3'd0);
        strobe(2'd2, 3'd0);
        strobe(2'd0, OP_ADD);
        tick();
        rsp_valid  = 1'b1;
        rsp_result = 2'd3;
        tick();
        rsp_valid  = 1'b0;
        check("chain_res", 8'({state_dbg, res_valid, res_out}), 8'b101_1_11);
        strobe(2'd1, 3'd0);
`ifdef ALU_SEQ_CHAIN_EN
        exp_chain_a = 2'd3;
`else
        exp_chain_a = 2'd1;
`endif
        check("chain_a", 8'(req_a), 8'(exp_chain_a));
        check("chain_state", 8'(state_dbg), 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
